text_stream_sequencer: RTL and testbench

- Sequences reads from the 256x8 text memory and streams the stored string to the downstream braille conversion path.
- On start, it first scans the memory from address 0 to find the string length, with 0x00 as the terminator.
- It then replays the characters one at a time over a valid/ready handshake.
- It is the sole driver of the memory read address, so the length and conversion consumers never contend for the port.

---
 rtl/text_stream_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_text_stream_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_stream_sequencer.sv
// text_stream_sequencer
//
// Purpose:
//   Drives the read port of the text memory. On start it first scans from
//   address 0 to find the string length (0x00 terminates), then replays the
//   characters one at a time to the braille converter over valid/ready.
//   Being the only source of mem_addr, it keeps the length measurement and
//   the character stream from contending for the memory port.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   begin a measure+stream pass (sampled in IDLE only)
//   abort      in   synchronous cancel, returns to IDLE without done
//   mem_addr   out  text memory read address
//   mem_dout   in   text memory read data (combinational from mem_addr)
//   char_data  out  character presented to the converter
//   char_valid out  char_data is valid
//   char_ready in   converter accepts char_data
//   text_len   out  measured string length (0..2^ADDR_W)
//   len_valid  out  text_len is valid for the current pass
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse at the end of a pass
module text_stream_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dout,
  output logic [7:0]        char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [LEN_W-1:0]  text_len,
  output logic              len_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  state_t             state_q, state_d;
  // One pointer serves as the scan address in MEASURE and the replay index
  // in STREAM; it is LEN_W wide so the replay index can reach 2^ADDR_W.
  logic [LEN_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
  logic [LEN_W-1:0]   text_len_q, text_len_d;
  logic               len_valid_q, len_valid_d;
  logic [7:0]         char_data_q, char_data_d;
  logic               char_valid_q, char_valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               slot_free;

  // Output slot can take a new character when empty or being drained.
  assign slot_free = !char_valid_q || char_ready;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    len_cnt_d    = len_cnt_q;
    text_len_d   = text_len_q;
    len_valid_d  = len_valid_q;
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_MEASURE;
          ptr_d       = '0;
          len_cnt_d   = '0;
          len_valid_d = 1'b0;
        end
      end

      S_MEASURE: begin
        if (mem_dout != 8'h00) begin
          len_cnt_d = len_cnt_q + LEN_ONE;
          if (ptr_q[ADDR_W-1:0] == ADDR_LAST) begin
            // No terminator anywhere: the whole memory is the string.
            text_len_d  = len_cnt_q + LEN_ONE;
            len_valid_d = 1'b1;
            ptr_d       = '0;
            state_d     = S_STREAM;
          end else begin
            ptr_d = ptr_q + LEN_ONE;
          end
        end else begin
          text_len_d  = len_cnt_q;
          len_valid_d = 1'b1;
          ptr_d       = '0;
          if (len_cnt_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_STREAM;
          end
        end
      end

      S_STREAM: begin
        if (slot_free) begin
          if (ptr_q < text_len_q) begin
            char_data_d  = mem_dout;
            char_valid_d = 1'b1;
            ptr_d        = ptr_q + LEN_ONE;
          end else begin
            char_valid_d = 1'b0;
            state_d      = S_DONE;
            done_d       = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything above, including a handshake this cycle.
    if (abort) begin
      state_d      = S_IDLE;
      ptr_d        = '0;
      len_cnt_d    = '0;
      text_len_d   = '0;
      len_valid_d  = 1'b0;
      char_valid_d = 1'b0;
      done_d       = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      len_cnt_q    <= '0;
      text_len_q   <= '0;
      len_valid_q  <= 1'b0;
      char_data_q  <= 8'h00;
      char_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      len_cnt_q    <= len_cnt_d;
      text_len_q   <= text_len_d;
      len_valid_q  <= len_valid_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // Address is forced to 0 outside the scan/replay states so the memory
  // port sits at a known location while idle.
  assign mem_addr   = ((state_q == S_MEASURE) || (state_q == S_STREAM)) ?
                      ptr_q[ADDR_W-1:0] : '0;
  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign text_len   = text_len_q;
  assign len_valid  = len_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_text_stream_sequencer.sv
module tb_text_stream_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] mem_addr;
  logic [7:0] mem_dout;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic [8:0] text_len;
  logic       len_valid;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  logic [7:0] txt [15];

  text_stream_sequencer #(.ADDR_W(8), .LEN_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .text_len   (text_len),
    .len_valid  (len_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  assign mem_dout = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q [$];
  int   hs_cnt = 0, done_cnt = 0, done_cyc = 0, lv_rise_cyc = 0;
  int   meas_k = 0, last_meas = 0, meas_bad = 0;
  logic prev_stall = 1'b0, lv_prev = 1'b0, cv_seen = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
        lv_prev    = 1'b0;
        meas_k     = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", int'(char_valid), 1);
          check("stall_data_held", int'(char_data), int'(prev_data));
        end
        if (char_valid) cv_seen = 1'b1;
        if (char_valid && char_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_char actual=%02h expected=none (cycle %0d)", char_data, cyc);
          end else begin
            e = exp_q.pop_front();
            $display("hs %0d: char=%02h expected=%02h", hs_cnt, char_data, e);
            check("char_data", int'(char_data), int'(e));
          end
        end
        prev_stall = char_valid && !char_ready;
        prev_data  = char_data;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (len_valid && !lv_prev) lv_rise_cyc = cyc;
        lv_prev = len_valid;
        // Busy with no valid length means the scan is running: address
        // must step 0,1,2,... with the scan cycle number.
        if (busy && !len_valid) begin
          if (int'(mem_addr) != meas_k) meas_bad++;
          meas_k++;
        end else if (meas_k != 0) begin
          last_meas = meas_k;
          meas_k    = 0;
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  int ready_mode = 0;
  initial begin
    int ph = 0;
    char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        char_ready = 1'b1;
      end else begin
        char_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    tick();
    start = 1'b1;
    s = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int  d0 = done_cnt;
    bit  ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done within %0d cycles", lim);
    end
  endtask

  task automatic wait_hs(input int target, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #1;
      if (hs_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout actual=%0d required=%0d", hs_cnt, target);
    end
  endtask

  task automatic load_text();
    for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
    for (int i = 0; i < 15; i++) mem[i] = txt[i];
    mem[15] = 8'h00;
  endtask

  task automatic push_text();
    for (int i = 0; i < 15; i++) exp_q.push_back(txt[i]);
  endtask

  // Full "Text to Braille" pass with char_ready held high and exact timing.
  task automatic text_pass(input string tag, input bit extra_start);
    int s, s2, h0, d0;
    load_text();
    h0 = hs_cnt;
    d0 = done_cnt;
    push_text();
    pulse_start(s);
    if (extra_start) begin
      repeat (20) tick();
      check({tag, "_busy_before_extra_start"}, int'(busy), 1);
      pulse_start(s2);
    end
    wait_done(200);
    check({tag, "_text_len"}, int'(text_len), 15);
    check({tag, "_len_valid"}, int'(len_valid), 1);
    check({tag, "_measure_cycles"}, last_meas, 16);
    check({tag, "_len_valid_cycle"}, lv_rise_cyc, s + 16);
    check({tag, "_done_cycle"}, done_cyc, s + 32);
    check({tag, "_handshakes"}, hs_cnt - h0, 15);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    repeat (40) tick();
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_done_after"}, int'(done), 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    $display("%s: pass complete, len=%0d", tag, text_len);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string s_txt = "Text to Braille";
    int s, h0, d0;
    for (int i = 0; i < 15; i++) txt[i] = s_txt[i];
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_char_data", int'(char_data), 0);
    check("rst_char_valid", int'(char_valid), 0);
    check("rst_text_len", int'(text_len), 0);
    check("rst_len_valid", int'(len_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b1;
    repeat (2) tick();

    // 1: basic pass
    text_pass("t1", 1'b0);

    // 2: stalling consumer
    load_text();
    ready_mode = 1;
    h0 = hs_cnt;
    push_text();
    pulse_start(s);
    wait_done(400);
    check("t2_handshakes", hs_cnt - h0, 15);
    check("t2_queue_left", exp_q.size(), 0);
    check("t2_text_len", int'(text_len), 15);
    ready_mode = 0;
    repeat (4) tick();
    $display("t2: stalled pass complete");

    // 3: empty string
    mem[0] = 8'h00;
    h0 = hs_cnt;
    cv_seen = 1'b0;
    pulse_start(s);
    wait_done(20);
    check("t3_text_len", int'(text_len), 0);
    check("t3_len_valid", int'(len_valid), 1);
    check("t3_done_cycle", done_cyc, s + 1);
    check("t3_measure_cycles", last_meas, 1);
    check("t3_char_valid_seen", int'(cv_seen), 0);
    check("t3_handshakes", hs_cnt - h0, 0);
    repeat (2) tick();
    $display("t3: empty string complete");

    // 4: full memory, no terminator
    for (int i = 0; i < 256; i++) mem[i] = 8'h41;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'h41);
    h0 = hs_cnt;
    meas_bad = 0;
    pulse_start(s);
    wait_done(1000);
    check("t4_text_len", int'(text_len), 256);
    check("t4_measure_cycles", last_meas, 256);
    check("t4_measure_addr_errors", meas_bad, 0);
    check("t4_done_cycle", done_cyc, s + 513);
    check("t4_handshakes", hs_cnt - h0, 256);
    check("t4_queue_left", exp_q.size(), 0);
    repeat (2) tick();
    $display("t4: full memory complete");

    // 5: abort after 5th handshake; accept in the abort cycle still counts
    load_text();
    h0 = hs_cnt;
    d0 = done_cnt;
    push_text();
    pulse_start(s);
    wait_hs(h0 + 5, 200);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", int'(busy), 0);
    check("t5_char_valid", int'(char_valid), 0);
    check("t5_len_valid", int'(len_valid), 0);
    check("t5_text_len", int'(text_len), 0);
    check("t5_handshakes", hs_cnt - h0, 6);
    exp_q.delete();
    repeat (10) tick();
    check("t5_no_done", done_cnt - d0, 0);
    $display("t5: abort complete");
    text_pass("t5_restart", 1'b0);

    // 6: async reset mid-stream, then a pass with a stray start while busy
    load_text();
    h0 = hs_cnt;
    push_text();
    pulse_start(s);
    wait_hs(h0 + 3, 200);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_mem_addr", int'(mem_addr), 0);
    check("t6_char_data", int'(char_data), 0);
    check("t6_char_valid", int'(char_valid), 0);
    check("t6_text_len", int'(text_len), 0);
    check("t6_len_valid", int'(len_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    $display("t6: reset mid-stream complete");
    repeat (2) tick();
    text_pass("t6_ignored_start", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end

endmodule
